// File: rtl/reorder_buffer.sv
// Purpose    : in-order retirement queue of the Tomasulo core; hands out tags at issue,
//              captures ALU results, retires in order and broadcasts each commit.
// Latency    : result at edge N marks the entry done; commit pulse is registered after edge N+1.
// Backpressure: issue_ready = !full on the current count; issue while full is dropped;
//              rdy_in low freezes all state.
// Ports      : clk_in/rst_n_in clock and async active-low reset; rdy_in global enable;
//              flush_in discards all entries; issue_* allocate; have_execute/entry_execute/result
//              write back; qry1_*/qry2_* combinational operand lookup with same-cycle bypass;
//              have_commit/entry_commit/destination_commit/value_commit registered commit broadcast.
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ROB_ADDR_W = 4,
    parameter int TAG_W      = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              have_execute,
    input  logic [TAG_W-1:0]  entry_execute,
    input  logic [31:0]       result,
    input  logic [TAG_W-1:0]  qry1_tag,
    input  logic [TAG_W-1:0]  qry2_tag,
    output logic              qry1_ready,
    output logic              qry2_ready,
    output logic [31:0]       qry1_value,
    output logic [31:0]       qry2_value,
    output logic              have_commit,
    output logic [TAG_W-1:0]  entry_commit,
    output logic [4:0]        destination_commit,
    output logic [31:0]       value_commit
);

    localparam logic [ROB_ADDR_W:0] SIZE_CNT = (ROB_ADDR_W+1)'(ROB_SIZE);
    localparam logic [TAG_W-1:0]    MAX_TAG  = TAG_W'(ROB_SIZE);

    logic [ROB_ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_ADDR_W:0]   count_q, count_d;
    logic [ROB_SIZE-1:0]   busy_q, busy_d, done_q, done_d;
    logic [4:0]            dest_q  [ROB_SIZE];
    logic [4:0]            dest_d  [ROB_SIZE];
    logic [31:0]           value_q [ROB_SIZE];
    logic [31:0]           value_d [ROB_SIZE];

    logic                  have_commit_q, have_commit_d;
    logic [TAG_W-1:0]      entry_commit_q, entry_commit_d;
    logic [4:0]            dest_commit_q, dest_commit_d;
    logic [31:0]           value_commit_q, value_commit_d;

    logic                  full;
    logic                  issue_fire;
    logic                  commit_fire;
    logic                  exec_hit;
    logic [ROB_ADDR_W-1:0] exec_idx;
    logic                  exec_in_range;

    // Tags are index+1; tag 0 and tags beyond ROB_SIZE address nothing.
    assign exec_in_range = (entry_execute != '0) && (entry_execute <= MAX_TAG);
    assign exec_idx      = entry_execute[ROB_ADDR_W-1:0] - ROB_ADDR_W'(1);
    assign exec_hit      = have_execute && exec_in_range && busy_q[exec_idx];

    // Full is taken from the current count, so a same-cycle commit never opens a slot.
    assign full        = (count_q == SIZE_CNT);
    assign issue_fire  = issue_valid && !full;
    assign commit_fire = busy_q[head_q] && done_q[head_q];

    assign issue_ready = !full;
    assign issue_tag   = TAG_W'(tail_q) + TAG_W'(1);

    assign have_commit        = have_commit_q;
    assign entry_commit       = entry_commit_q;
    assign destination_commit = dest_commit_q;
    assign value_commit       = value_commit_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        done_d         = done_q;
        dest_d         = dest_q;
        value_d        = value_q;
        have_commit_d  = 1'b0;
        entry_commit_d = entry_commit_q;
        dest_commit_d  = dest_commit_q;
        value_commit_d = value_commit_q;

        if (rdy_in) begin
            if (flush_in) begin
                busy_d  = '0;
                done_d  = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (exec_hit) begin
                    done_d[exec_idx]  = 1'b1;
                    value_d[exec_idx] = result;
                end
                // Commit reads the registered entry, so a result landing this cycle
                // retires no earlier than the following edge.
                if (commit_fire) begin
                    have_commit_d  = 1'b1;
                    entry_commit_d = TAG_W'(head_q) + TAG_W'(1);
                    dest_commit_d  = dest_q[head_q];
                    value_commit_d = value_q[head_q];
                    busy_d[head_q] = 1'b0;
                    done_d[head_q] = 1'b0;
                    head_d         = head_q + ROB_ADDR_W'(1);
                end
                // Tail slot is never busy when not full, so it cannot collide with
                // the writeback or commit above.
                if (issue_fire) begin
                    busy_d[tail_q] = 1'b1;
                    done_d[tail_q] = 1'b0;
                    dest_d[tail_q] = issue_dest;
                    tail_d         = tail_q + ROB_ADDR_W'(1);
                end
                count_d = count_q + (ROB_ADDR_W+1)'(issue_fire) - (ROB_ADDR_W+1)'(commit_fire);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            done_q         <= '0;
            have_commit_q  <= 1'b0;
            entry_commit_q <= '0;
            dest_commit_q  <= '0;
            value_commit_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            have_commit_q  <= have_commit_d;
            entry_commit_q <= entry_commit_d;
            dest_commit_q  <= dest_commit_d;
            value_commit_q <= value_commit_d;
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest_q[i]  <= dest_d[i];
                value_q[i] <= value_d[i];
            end
        end
    end

    // Operand lookup: a result on the bus this cycle wins over the stored state.
    logic                  q1_in_range, q2_in_range;
    logic [ROB_ADDR_W-1:0] q1_idx, q2_idx;

    assign q1_in_range = (qry1_tag != '0) && (qry1_tag <= MAX_TAG);
    assign q2_in_range = (qry2_tag != '0) && (qry2_tag <= MAX_TAG);
    assign q1_idx      = qry1_tag[ROB_ADDR_W-1:0] - ROB_ADDR_W'(1);
    assign q2_idx      = qry2_tag[ROB_ADDR_W-1:0] - ROB_ADDR_W'(1);

    always_comb begin
        qry1_ready = 1'b0;
        qry1_value = '0;
        if (q1_in_range) begin
            if (have_execute && (entry_execute == qry1_tag)) begin
                qry1_ready = 1'b1;
                qry1_value = result;
            end else begin
                qry1_ready = busy_q[q1_idx] && done_q[q1_idx];
                qry1_value = value_q[q1_idx];
            end
        end
    end

    always_comb begin
        qry2_ready = 1'b0;
        qry2_value = '0;
        if (q2_in_range) begin
            if (have_execute && (entry_execute == qry2_tag)) begin
                qry2_ready = 1'b1;
                qry2_value = result;
            end else begin
                qry2_ready = busy_q[q2_idx] && done_q[q2_idx];
                qry2_value = value_q[q2_idx];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Purpose    : directed bench for reorder_buffer with an in-order commit scoreboard.
// Latency    : inputs driven 1 time unit after each rising edge, outputs sampled there.
// Backpressure: the bench models the occupancy count to predict dropped issues.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic [4:0]  issue_tag;
    logic        have_execute;
    logic [4:0]  entry_execute;
    logic [31:0] result;
    logic [4:0]  qry1_tag, qry2_tag;
    logic        qry1_ready, qry2_ready;
    logic [31:0] qry1_value, qry2_value;
    logic        have_commit;
    logic [4:0]  entry_commit;
    logic [4:0]  destination_commit;
    logic [31:0] value_commit;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_SIZE(16), .ROB_ADDR_W(4), .TAG_W(5)) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .rdy_in             (rdy_in),
        .flush_in           (flush_in),
        .issue_valid        (issue_valid),
        .issue_dest         (issue_dest),
        .issue_ready        (issue_ready),
        .issue_tag          (issue_tag),
        .have_execute       (have_execute),
        .entry_execute      (entry_execute),
        .result             (result),
        .qry1_tag           (qry1_tag),
        .qry2_tag           (qry2_tag),
        .qry1_ready         (qry1_ready),
        .qry2_ready         (qry2_ready),
        .qry1_value         (qry1_value),
        .qry2_value         (qry2_value),
        .have_commit        (have_commit),
        .entry_commit       (entry_commit),
        .destination_commit (destination_commit),
        .value_commit       (value_commit)
    );

    typedef struct packed {
        logic [4:0] tag;
        logic [4:0] dest;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] mval [32];
    logic [3:0]  mtail;
    int          mcount;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Advance one edge: update the model for what the DUT accepts at this edge,
    // then score any commit that appears after it.
    task automatic tick();
        exp_t e;
        if (rdy_in && flush_in) begin
            sb.delete();
            mtail  = '0;
            mcount = 0;
        end else if (rdy_in && issue_valid && mcount < 16) begin
            e.tag  = 5'(mtail) + 5'd1;
            e.dest = issue_dest;
            sb.push_back(e);
            mtail  = mtail + 4'd1;
            mcount++;
        end
        @(posedge clk_in);
        #1;
        if (have_commit) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 32'(have_commit), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("commit_tag",   32'(entry_commit),       32'(e.tag));
                chk("commit_dest",  32'(destination_commit), 32'(e.dest));
                chk("commit_value", value_commit,            mval[e.tag]);
                mcount--;
            end
        end
        issue_valid  = 1'b0;
        have_execute = 1'b0;
        flush_in     = 1'b0;
    endtask

    task automatic issue(input logic [4:0] d);
        chk("issue_tag",   32'(issue_tag),   32'(5'(mtail) + 5'd1));
        chk("issue_ready", 32'(issue_ready), (mcount < 16) ? 32'd1 : 32'd0);
        issue_valid = 1'b1;
        issue_dest  = d;
        tick();
    endtask

    task automatic execute(input logic [4:0] t, input logic [31:0] v);
        have_execute  = 1'b1;
        entry_execute = t;
        result        = v;
        mval[t]       = v;
        tick();
    endtask

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        issue_valid   = 1'b0;
        issue_dest    = '0;
        have_execute  = 1'b0;
        entry_execute = '0;
        result        = '0;
        qry1_tag      = '0;
        qry2_tag      = '0;
        mtail         = '0;
        mcount        = 0;
        for (int i = 0; i < 32; i++) mval[i] = '0;

        // Reset state
        #12;
        rst_n_in = 1'b1;
        #2;
        chk("rst_issue_ready", 32'(issue_ready),        32'd1);
        chk("rst_issue_tag",   32'(issue_tag),          32'd1);
        chk("rst_have_commit", 32'(have_commit),        32'd0);
        chk("rst_entry",       32'(entry_commit),       32'd0);
        chk("rst_dest",        32'(destination_commit), 32'd0);
        chk("rst_value",       value_commit,            32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_commit", 32'(have_commit), 32'd0);
        end

        // In-order retirement with out-of-order completion
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        execute(5'd2, 32'h22);
        chk("order_no_early", 32'(have_commit), 32'd0);
        execute(5'd1, 32'h11);
        chk("order_latency", 32'(have_commit), 32'd0);
        tick();
        chk("order_commit1", 32'(have_commit), 32'd1);
        tick();
        chk("order_commit2", 32'(have_commit), 32'd1);
        tick();
        chk("order_tag3_pending", 32'(have_commit), 32'd0);

        // Flush with a simultaneous issue
        issue(5'd4);
        issue(5'd5);
        issue(5'd6);
        execute(5'd4, 32'h44);
        execute(5'd5, 32'h55);
        flush_in    = 1'b1;
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        tick();
        chk("flush_issue_tag",   32'(issue_tag),   32'd1);
        chk("flush_issue_ready", 32'(issue_ready), 32'd1);
        execute(5'd3, 32'h33);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_no_commit", 32'(have_commit), 32'd0);
        end

        // Fill to capacity, drop while full, wrap the tail
        for (int i = 0; i < 16; i++) issue(5'(i + 1));
        chk("full_not_ready", 32'(issue_ready), 32'd0);
        issue(5'd17);
        chk("full_drop_no_commit", 32'(have_commit), 32'd0);
        execute(5'd1, 32'h100);
        issue_valid = 1'b1;
        issue_dest  = 5'd20;
        tick();
        chk("full_commit_tag1", 32'(have_commit), 32'd1);
        chk("wrap_ready",       32'(issue_ready), 32'd1);
        chk("wrap_tag",         32'(issue_tag),   32'd1);
        issue(5'd21);
        chk("refull_not_ready", 32'(issue_ready), 32'd0);

        // Operand forwarding
        execute(5'd2, 32'hAB);
        qry1_tag = 5'd2;
        #1;
        chk("fwd_stored_ready", 32'(qry1_ready), 32'd1);
        chk("fwd_stored_value", qry1_value,      32'hAB);
        have_execute  = 1'b1;
        entry_execute = 5'd3;
        result        = 32'h5;
        mval[3]       = 32'h5;
        qry2_tag      = 5'd3;
        #1;
        chk("fwd_bypass_ready", 32'(qry2_ready), 32'd1);
        chk("fwd_bypass_value", qry2_value,      32'h5);
        qry1_tag = 5'd0;
        #1;
        chk("fwd_tag0_ready", 32'(qry1_ready), 32'd0);
        chk("fwd_tag0_value", qry1_value,      32'd0);
        qry1_tag = 5'd4;
        #1;
        chk("fwd_not_done", 32'(qry1_ready), 32'd0);
        tick();
        chk("fwd_commit2", 32'(have_commit), 32'd1);
        tick();
        chk("fwd_commit3", 32'(have_commit), 32'd1);
        tick();
        chk("fwd_idle", 32'(have_commit), 32'd0);

        // Global stall
        execute(5'd4, 32'h44);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                issue_valid = 1'b1;
                issue_dest  = 5'd9;
            end
            tick();
            chk("stall_no_commit", 32'(have_commit), 32'd0);
            chk("stall_tail_held", 32'(issue_tag),   32'(5'(mtail) + 5'd1));
            chk("stall_head_done", 32'(qry1_ready),  32'd1);
            chk("stall_head_val",  qry1_value,       32'h44);
        end
        rdy_in = 1'b1;
        tick();
        chk("stall_release_commit", 32'(have_commit), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
